tone_oscillator: RTL and testbench

- Downstream consumer of the period lookup (octave/note -> 24-bit signed period in clk cycles).
- Turns a period into a gated, enveloped square-wave audio sample stream for the audio codec write path.
- Contains a phase counter, a pending-period register so pitch changes do not glitch, and an attack/sustain/release gain state machine stepped by the codec sample strobe.

---
 rtl/tone_oscillator_if.sv | 24 ++
 rtl/tone_oscillator.sv | 140 ++++++++++++++
 tb/tb_tone_oscillator.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/tone_oscillator_if.sv
// Key/sample handshake bundle between the note controller, the codec write path and tone_oscillator.
// Master drives keys, period and sample requests; slave returns the enveloped sample stream.
interface tone_oscillator_if #(
  parameter int PERIOD_W = 24,
  parameter int SAMPLE_W = 24
);
  logic                       key_down;
  logic                       key_up;
  logic signed [PERIOD_W-1:0] period_in;
  logic                       sample_req;
  logic signed [SAMPLE_W-1:0] sample_out;
  logic                       sample_valid;
  logic                       active;

  modport master (
    output key_down, key_up, period_in, sample_req,
    input  sample_out, sample_valid, active
  );

  modport slave (
    input  key_down, key_up, period_in, sample_req,
    output sample_out, sample_valid, active
  );
endinterface

// File: rtl/tone_oscillator.sv
// Gated square-wave tone with attack/sustain/release gain; sample_out/sample_valid follow sample_req by 1 clk.
// No backpressure: every sample_req is answered on the next cycle, pitch changes wait for a period wrap.
module tone_oscillator #(
  parameter int          PERIOD_W     = 24,
  parameter int          SAMPLE_W     = 24,
  parameter int unsigned AMP          = 4194304,
  parameter int unsigned ATTACK_STEP  = 64,
  parameter int unsigned RELEASE_STEP = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  tone_oscillator_if.slave osc
);

  typedef enum logic [1:0] {IDLE, ATTACK, SUSTAIN, RELEASE} state_e;

  localparam logic signed [PERIOD_W-1:0] ONE_S   = 1;
  localparam logic        [PERIOD_W-1:0] TWO     = 2;
  localparam logic        [7:0]          GAIN_MX = 8'hFF;

  state_e                     state_q, state_d, env_st;
  logic [PERIOD_W-1:0]        cnt_q, cnt_d;
  logic [PERIOD_W-1:0]        period_q, period_d;
  logic [PERIOD_W-1:0]        pending_q, pending_d;
  logic [PERIOD_W-1:0]        period_san;
  logic                       pend_flag_q, pend_flag_d;
  logic [7:0]                 gain_q, gain_d;
  logic [7:0]                 gain_up, gain_dn;
  logic [31:0]                up_sum;
  logic [31:0]                prod;
  logic [SAMPLE_W-1:0]        mag;
  logic                       level;
  logic signed [SAMPLE_W-1:0] sample_q, sample_d;
  logic                       valid_q, valid_d;
  logic                       active_q;

  assign period_san = (osc.period_in <= ONE_S) ? TWO : osc.period_in;
  assign level      = (cnt_q < (period_q >> 1));
  assign up_sum     = 32'(gain_q) + ATTACK_STEP;
  assign gain_up    = (up_sum > 32'd255) ? GAIN_MX : up_sum[7:0];
  assign gain_dn    = (32'(gain_q) > RELEASE_STEP) ? 8'(32'(gain_q) - RELEASE_STEP) : 8'h00;

  always_comb begin
    // Envelope rule for this cycle already reflects a same-cycle key event.
    env_st = state_q;
    if (osc.key_down) begin
      env_st = ATTACK;
    end else if (osc.key_up && (state_q == ATTACK || state_q == SUSTAIN)) begin
      env_st = RELEASE;
    end

    state_d     = env_st;
    cnt_d       = cnt_q;
    period_d    = period_q;
    pending_d   = pending_q;
    pend_flag_d = pend_flag_q;
    gain_d      = gain_q;
    sample_d    = sample_q;
    valid_d     = 1'b0;
    prod        = '0;
    mag         = '0;

    if (state_q != IDLE) begin
      if (cnt_q == period_q - TWO + 1'b1) begin
        cnt_d = '0;
        if (pend_flag_q) begin
          period_d    = pending_q;
          pend_flag_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (osc.key_down) begin
      if (state_q == IDLE) begin
        period_d    = period_san;
        cnt_d       = '0;
        pend_flag_d = 1'b0;
      end else begin
        pending_d   = period_san;
        pend_flag_d = 1'b1;
      end
    end

    if (osc.sample_req) begin
      valid_d = 1'b1;
      unique case (env_st)
        ATTACK: begin
          gain_d = gain_up;
          if (gain_up == GAIN_MX) state_d = SUSTAIN;
        end
        RELEASE: begin
          gain_d = gain_dn;
          if (gain_dn == 8'h00) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        default: ;
      endcase
      prod = AMP * 32'(gain_d);
      mag  = SAMPLE_W'(prod >> 8);
      if (env_st == IDLE) begin
        sample_d = '0;
      end else begin
        sample_d = level ? mag : -mag;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      period_q    <= TWO;
      pending_q   <= TWO;
      pend_flag_q <= 1'b0;
      gain_q      <= '0;
      sample_q    <= '0;
      valid_q     <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      period_q    <= period_d;
      pending_q   <= pending_d;
      pend_flag_q <= pend_flag_d;
      gain_q      <= gain_d;
      sample_q    <= sample_d;
      valid_q     <= valid_d;
      active_q    <= (state_d != IDLE);
    end
  end

  assign osc.sample_out   = sample_q;
  assign osc.sample_valid = valid_q;
  assign osc.active       = active_q;

endmodule

// File: tb/tb_tone_oscillator.sv
// Randomised and directed bench for tone_oscillator against an integer envelope/phase model.
module tb_tone_oscillator;

  localparam int AMP = 4194304;
  localparam int S_IDLE = 0, S_ATK = 1, S_SUS = 2, S_REL = 3;

  logic clk;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  bit   started = 0;

  tone_oscillator_if #(.PERIOD_W(24), .SAMPLE_W(24)) osc ();

  tone_oscillator dut (
    .clk     (clk),
    .reset_n (reset_n),
    .osc     (osc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: note state, gain 0..255, position within the current period, queued period (0 = none).
  int m_st, m_gain, m_pos, m_per, m_pend, m_out, m_vld, m_act;

  task m_reset();
    m_st = S_IDLE; m_gain = 0; m_pos = 0; m_per = 2; m_pend = 0;
    m_out = 0; m_vld = 0; m_act = 0;
  endtask

  task m_step();
    int eff, nxt, san, mag;
    bit lvl;
    lvl = (m_pos < m_per / 2);
    eff = m_st;
    if (osc.key_down) eff = S_ATK;
    else if (osc.key_up && (m_st == S_ATK || m_st == S_SUS)) eff = S_REL;
    nxt = eff;
    if (m_st != S_IDLE) begin
      m_pos = m_pos + 1;
      if (m_pos == m_per) begin
        m_pos = 0;
        if (m_pend != 0) begin
          m_per  = m_pend;
          m_pend = 0;
        end
      end
    end
    if (osc.key_down) begin
      san = int'(osc.period_in);
      if (san <= 1) san = 2;
      if (m_st == S_IDLE) begin
        m_per = san; m_pos = 0; m_pend = 0;
      end else begin
        m_pend = san;
      end
    end
    m_vld = 0;
    if (osc.sample_req) begin
      m_vld = 1;
      if (eff == S_ATK) begin
        m_gain = (m_gain + 64 > 255) ? 255 : m_gain + 64;
        if (m_gain == 255) nxt = S_SUS;
      end else if (eff == S_REL) begin
        m_gain = (m_gain < 64) ? 0 : m_gain - 64;
        if (m_gain == 0) begin
          nxt   = S_IDLE;
          m_pos = 0;
        end
      end
      mag   = (AMP * m_gain) / 256;
      m_out = (eff == S_IDLE) ? 0 : (lvl ? mag : -mag);
    end
    m_st  = nxt;
    m_act = (m_st != S_IDLE) ? 1 : 0;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) m_reset();
      else m_step();
    end
  end

  task chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        chk("cyc_sample_out", int'(osc.sample_out), m_out);
        chk("cyc_sample_valid", int'(osc.sample_valid), m_vld);
        chk("cyc_active", int'(osc.active), m_act);
      end
    end
  end

  // Literal expectation checked against both the DUT and the model.
  task lit(input string name, input int exp);
    chk({name, "_dut"}, int'(osc.sample_out), exp);
    chk({name, "_model"}, m_out, exp);
  endtask

  task tick(input bit kd, input bit ku, input bit rq, input int pin);
    osc.key_down   = kd;
    osc.key_up     = ku;
    osc.sample_req = rq;
    osc.period_in  = 24'(pin);
    @(posedge clk);
    #1;
    osc.key_down   = 1'b0;
    osc.key_up     = 1'b0;
    osc.sample_req = 1'b0;
  endtask

  int abs_v;
  int exp_sign;

  initial begin
    reset_n        = 1'b0;
    osc.key_down   = 1'b0;
    osc.key_up     = 1'b0;
    osc.sample_req = 1'b0;
    osc.period_in  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sample_out", int'(osc.sample_out), 0);
    chk("rst_sample_valid", int'(osc.sample_valid), 0);
    chk("rst_active", int'(osc.active), 0);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1 started = 1;

    // Idle requests produce zero samples.
    for (int i = 0; i < 4; i++) begin
      tick(0, 0, 1, 0);
      chk("idle_valid", int'(osc.sample_valid), 1);
      lit("idle_out", 0);
      chk("idle_active", int'(osc.active), 0);
    end

    // Attack ramp on the high phase of period 8.
    tick(1, 0, 0, 8);
    tick(0, 0, 1, 0); lit("atk1", 1048576);
    tick(0, 0, 1, 0); lit("atk2", 2097152);
    tick(0, 0, 1, 0); lit("atk3", 3145728);
    tick(0, 0, 1, 0); lit("atk4", 4177920);
    chk("atk_active", int'(osc.active), 1);

    // Low phase in sustain.
    tick(0, 0, 1, 0); lit("sus_low", -4177920);

    // Retrigger with period 12 at cnt 3: finish period 8, then 6 high / 6 low.
    repeat (6) tick(0, 0, 0, 0);
    tick(1, 0, 0, 12);
    for (int i = 0; i < 16; i++) begin
      tick(0, 0, 1, 0);
      exp_sign = (i < 4) ? -1 : (i < 10) ? 1 : -1;
      lit("pend_period", exp_sign * 4177920);
    end

    // Release ramp.
    tick(0, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tick(0, 0, 1, 0);
      abs_v = (osc.sample_out < 0) ? -int'(osc.sample_out) : int'(osc.sample_out);
      chk("rel_mag", abs_v, (i == 0) ? 3129344 : (i == 1) ? 2080768 : (i == 2) ? 1032192 : 0);
      chk("rel_active", int'(osc.active), (i == 3) ? 0 : 1);
    end

    // key_down beats key_up in the same cycle.
    tick(1, 1, 0, 8);
    chk("kd_wins_active", int'(osc.active), 1);
    tick(0, 1, 0, 0);
    tick(0, 0, 1, 0);
    chk("kd_wins_idle", int'(osc.active), 0);
    lit("kd_wins_out", 0);

    // Negative period sanitises to 2: level alternates every clock.
    tick(1, 0, 1, -5); lit("p2_0", 1048576);
    tick(0, 0, 1, 0);  lit("p2_1", 2097152);
    tick(0, 0, 1, 0);  lit("p2_2", -3145728);
    tick(0, 0, 1, 0);  lit("p2_3", 4177920);
    tick(0, 0, 1, 0);  lit("p2_4", -4177920);

    // Async reset in the middle of an attack.
    tick(0, 1, 0, 0);
    repeat (4) tick(0, 0, 1, 0);
    tick(1, 0, 0, 8);
    tick(0, 0, 1, 0);
    lit("pre_rst", 1048576);
    osc.sample_req = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_out", int'(osc.sample_out), 0);
    chk("mid_rst_valid", int'(osc.sample_valid), 0);
    chk("mid_rst_active", int'(osc.active), 0);
    osc.sample_req = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 39) == 0, $urandom_range(0, 29) == 0,
           $urandom_range(0, 2) == 0, int'($urandom_range(0, 24)) - 4);
    end

    repeat (2) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
